regfile_dump: RTL and testbench

Sequential read-out engine for the 32×32 register file: on a start pulse it walks a contiguous, wrap-around range of register indices through one read port and emits each value as a valid/ready beat (index + data) toward the testbench or debug link. It is the consumer/reader counterpart to the register file's write side. It lives beside the datapath and uses a spare combinational read port.

---
 rtl/regfile_dump.sv | 129 ++++++++++++
 tb/tb_regfile_dump.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Sequential register-file read-out engine: walks a wrap-around index range and
// emits valid/ready beats. Optional trailing checksum beat: REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  first_reg,
  input  logic [4:0]  last_reg,
  input  logic        abort,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_addr,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        out_is_sum,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, READ, SEND, SUM, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  ptr_p0;
  logic [4:0]  last_p0;
  logic [4:0]  addr_p1;
  logic [31:0] data_p1;
  logic        last_p1;
  logic        hs;
  logic        at_last;

  assign at_last = (ptr_p0 == last_p0);

  always_comb begin
    state_nxt = state;
    hs        = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = READ;
      READ: state_nxt = SEND;
      SEND: begin
        hs = out_ready;
        if (out_ready) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
          state_nxt = at_last ? SUM : READ;
`else
          state_nxt = at_last ? DONE : READ;
`endif
        end
      end
      SUM:  if (out_ready) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // abort wins over any handshake presented in the same cycle
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      hs        = 1'b0;
    end
  end

  // stage p0: range pointer and control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr_p0  <= 5'd0;
      last_p0 <= 5'd0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        ptr_p0  <= first_reg;
        last_p0 <= last_reg;
      end else if (hs && !at_last) begin
        ptr_p0 <= ptr_p0 + 5'd1;
      end
    end
  end

  // stage p1: captured beat, held stable while SEND waits for ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p1 <= 5'd0;
      data_p1 <= 32'd0;
      last_p1 <= 1'b0;
    end else if (state == READ) begin
      addr_p1 <= ptr_p0;
      data_p1 <= rf_data;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      last_p1 <= 1'b0;
`else
      last_p1 <= at_last;
`endif
    end
  end

  assign rf_addr   = ptr_p0;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_valid = (state == SEND) || (state == SUM);

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [31:0] csum_p1;

  function automatic logic [31:0] wrap_add(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_p1 <= 32'd0;
    end else if ((state == IDLE) && start) begin
      csum_p1 <= 32'd0;
    end else if (hs) begin
      csum_p1 <= wrap_add(csum_p1, data_p1);
    end
  end

  assign out_is_sum = (state == SUM);
  assign out_data   = (state == SUM) ? csum_p1 : data_p1;
  assign out_addr   = (state == SUM) ? 5'd0 : addr_p1;
  assign out_last   = (state == SUM) || ((state == SEND) && last_p1);
`else
  assign out_is_sum = 1'b0;
  assign out_data   = data_p1;
  assign out_addr   = addr_p1;
  assign out_last   = (state == SEND) && last_p1;
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: table-driven dumps, randomized ranges/ready,
// and hand-written abort / reset sequences against a list-based reference model.
module tb_regfile_dump;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  first_reg = 5'd0;
  logic [4:0]  last_reg = 5'd0;
  logic        abort = 1'b0;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_is_sum;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];
  int checks = 0;
  int errors = 0;

  assign rf_data = regs[rf_addr];

  always #5 clk = ~clk;

  regfile_dump dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .abort(abort), .rf_addr(rf_addr), .rf_data(rf_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
    .out_is_sum(out_is_sum), .busy(busy), .done(done)
  );

  typedef struct {
    logic [4:0] f;
    logic [4:0] l;
    int         mode;  // 0 ready high, 1 random ready, 2 stall beat 2, 3 start while busy
    int         n;     // expected register beats
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_rf_addr"}, 32'(rf_addr), 32'd0);
    chk({name, "_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_addr"}, 32'(out_addr), 32'd0);
    chk({name, "_data"}, out_data, 32'd0);
    chk({name, "_last"}, 32'(out_last), 32'd0);
    chk({name, "_is_sum"}, 32'(out_is_sum), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode, input int n);
    int beat = 0;
    int stall = 0;
    int first_v = -1;
    int done_k = -1;
    int total;
    bit prev_v = 0;
    bit prev_hs = 0;
    bit hs;
    logic [4:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;
    logic [4:0]  idx;
    logic [31:0] sum = 32'd0;
    bit finished = 0;

    total = n + CS;
    for (int i = 0; i < n; i++) sum = sum + regs[5'(int'(f) + i)];

    @(negedge clk);
    first_reg = f;
    last_reg  = l;
    start     = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (mode == 3 && k == 3) begin
        first_reg = 5'd0;
        last_reg  = 5'd20;
        start     = 1'b1;
      end
      if (mode == 3 && k == 4) begin
        first_reg = f;
        last_reg  = l;
      end
      if (k == 1) chk("busy_in_read", 32'(busy), 32'd1);
      if (done_k >= 0) begin
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
        finished = 1;
        break;
      end
      case (mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: if (out_valid && beat == 1 && stall < 5) begin
             out_ready = 1'b0;
             stall++;
           end else out_ready = 1'b1;
        default: out_ready = 1'b1;
      endcase
      if (prev_v && !prev_hs) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_addr", 32'(out_addr), 32'(prev_addr));
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && first_v < 0) first_v = k;
      hs = out_valid && out_ready;
      if (hs) begin
        if (beat >= total) begin
          checks++;
          errors++;
          $display("FAIL extra_beat actual=%0d required_max=%0d", beat + 1, total);
        end else if (beat < n) begin
          idx = 5'(int'(f) + beat);
          chk("beat_addr", 32'(out_addr), 32'(idx));
          chk("beat_data", out_data, regs[idx]);
          chk("beat_last", 32'(out_last), 32'((beat == n - 1) && (CS == 0)));
          chk("beat_is_sum", 32'(out_is_sum), 32'd0);
        end else begin
          chk("sum_addr", 32'(out_addr), 32'd0);
          chk("sum_data", out_data, sum);
          chk("sum_last", 32'(out_last), 32'd1);
          chk("sum_is_sum", 32'(out_is_sum), 32'd1);
        end
        beat++;
      end
      if (done) begin
        done_k = k;
        chk("beat_count", 32'(beat), 32'(total));
        if (mode == 0) begin
          chk("first_valid_cycle", 32'(first_v), 32'd2);
          chk("done_cycle", 32'(done_k), 32'(2 * n + 1 + CS));
        end
      end
      prev_v    = out_valid;
      prev_hs   = hs;
      prev_addr = out_addr;
      prev_data = out_data;
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL dump_timeout first=%0d last=%0d beats=%0d required=%0d", f, l, beat, total);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
  endtask

  vec_t tbl[8];

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i * 7);
    regs[0]  = 32'h0000_0000;
    regs[8]  = 32'h11;
    regs[9]  = 32'h22;
    regs[10] = 32'h33;

    tbl[0] = '{f: 5'd8,  l: 5'd10, mode: 0, n: 3};
    tbl[1] = '{f: 5'd30, l: 5'd1,  mode: 0, n: 4};
    tbl[2] = '{f: 5'd12, l: 5'd15, mode: 2, n: 4};
    tbl[3] = '{f: 5'd20, l: 5'd22, mode: 3, n: 3};
    tbl[4] = '{f: 5'd5,  l: 5'd5,  mode: 1, n: 1};
    tbl[5] = '{f: 5'd0,  l: 5'd31, mode: 0, n: 32};
    tbl[6] = '{f: 5'd7,  l: 5'd6,  mode: 1, n: 32};
    tbl[7] = '{f: 5'd31, l: 5'd0,  mode: 0, n: 2};

    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("after_reset");

    for (int i = 0; i < 8; i++) run_dump(tbl[i].f, tbl[i].l, tbl[i].mode, tbl[i].n);

    // abort while beat 2 is being offered, with ready high in the same cycle
    @(negedge clk);
    first_reg = 5'd8;
    last_reg  = 5'd12;
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_valid", 32'(out_valid), 32'd1);
    chk("abort_pre_addr", 32'(out_addr), 32'd9);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_last", 32'(out_last), 32'd0);
    chk("abort_is_sum", 32'(out_is_sum), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    run_dump(5'd2, 5'd4, 0, 3);

    // asynchronous reset while in READ
    @(negedge clk);
    first_reg = 5'd4;
    last_reg  = 5'd6;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_busy", 32'(busy), 32'd0);
    chk("rst_release_valid", 32'(out_valid), 32'd0);
    run_dump(5'd4, 5'd6, 0, 3);

    // randomized ranges, contents and ready behaviour
    for (int r = 0; r < 20; r++) begin
      logic [4:0] f;
      logic [4:0] l;
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      f = 5'($urandom_range(0, 31));
      l = 5'($urandom_range(0, 31));
      run_dump(f, l, int'($urandom_range(0, 2)), int'(5'(l - f)) + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
